// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
// Memory-access stage sitting behind the decoder. Accepts one decoded memory
// operation at a time, runs a request/grant (+ read-data) transaction on the
// data-memory port or a request/acknowledge handoff to the DMA/PIM engine,
// stalls the upstream pipeline while busy and returns aligned, extended load
// data.
//
// Ports
//   clk_i, rst_i            core clock, asynchronous active-high reset
//   mem_read_i/mem_write_i  decoded load / store request
//   d_size_i                size mask (0001 byte, 0011 half, 1111 word)
//   d_unsigned_i            zero-extend loads
//   dma_en_i                route a store to the DMA/PIM engine instead
//   addr_i, wdata_i         byte address and store data from execute
//   stall_o                 hold upstream stages
//   dmem_*                  data-memory request/grant/read-data port
//   dma_*                   DMA command request/acknowledge port
//   load_data_o/valid_o     extended load result, one-cycle valid pulse
//   misaligned_o            one-cycle flag, the offending access is dropped
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [3:0]      d_size_i,
  input  logic            d_unsigned_i,
  input  logic            dma_en_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            dma_req_o,
  output logic [XLEN-1:0] dma_addr_o,
  output logic [XLEN-1:0] dma_data_o,
  input  logic            dma_ack_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            load_valid_o,
  output logic            misaligned_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT_R = 3'd2;
  localparam logic [2:0] ST_DMA    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;

  logic [2:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [3:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] load_data_q, load_data_d;

  logic            size_legal;
  logic            op_present;
  logic            misaligned;
  logic            accept;
  logic [3:0]      be;
  logic [XLEN-1:0] store_lanes;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_ext;

  // Decode of the incoming request while idle.
  always_comb begin
    size_legal = (d_size_i == SZ_BYTE) || (d_size_i == SZ_HALF) || (d_size_i == SZ_WORD);
    op_present = (mem_read_i | mem_write_i) & size_legal;
    misaligned = ((d_size_i == SZ_HALF) & addr_i[0]) |
                 ((d_size_i == SZ_WORD) & (addr_i[1:0] != 2'b00));
    accept     = (state_q == ST_IDLE) & op_present & ~misaligned;
  end

  // Byte enables: size mask shifted up to the byte offset, upper bits fall off.
  always_comb begin
    be = size_q;
    case (addr_q[1:0])
      2'd0: be = size_q;
      2'd1: be = {size_q[2:0], 1'b0};
      2'd2: be = {size_q[1:0], 2'b00};
      2'd3: be = {size_q[0], 3'b000};
      default: be = size_q;
    endcase
  end

  // Store data replicated across lanes so the memory only needs the enables.
  always_comb begin
    store_lanes = wdata_q;
    if (size_q == SZ_BYTE) begin
      store_lanes = {4{wdata_q[7:0]}};
    end else if (size_q == SZ_HALF) begin
      store_lanes = {2{wdata_q[15:0]}};
    end
  end

  // Bring the addressed bytes down to bit 0, then sign- or zero-extend.
  always_comb begin
    rdata_shifted = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    load_ext      = rdata_shifted;
    if (size_q == SZ_BYTE) begin
      load_ext = {{24{rdata_shifted[7] & ~unsigned_q}}, rdata_shifted[7:0]};
    end else if (size_q == SZ_HALF) begin
      load_ext = {{16{rdata_shifted[15] & ~unsigned_q}}, rdata_shifted[15:0]};
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // A simultaneous read+write request is treated as a store.
          we_d       = mem_write_i;
          size_d     = d_size_i;
          unsigned_d = d_unsigned_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          state_d    = (dma_en_i & mem_write_i) ? ST_DMA : ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          state_d = we_q ? ST_DONE : ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (dmem_rvalid_i) begin
          load_data_d = load_ext;
          state_d     = ST_DONE;
        end
      end
      ST_DMA: begin
        if (dma_ack_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 4'b0000;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // The idle-cycle outputs depend on live inputs; gate them with reset so
  // every output reads zero while reset is held.
  always_comb begin
    stall_o      = ~rst_i & (accept |
                             (state_q == ST_REQ) |
                             (state_q == ST_WAIT_R) |
                             (state_q == ST_DMA));
    misaligned_o = ~rst_i & (state_q == ST_IDLE) & op_present & misaligned;

    dmem_req_o   = (state_q == ST_REQ);
    dmem_we_o    = dmem_req_o & we_q;
    dmem_addr_o  = dmem_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
    dmem_be_o    = dmem_req_o ? be : 4'b0000;
    dmem_wdata_o = (dmem_req_o & we_q) ? store_lanes : '0;

    dma_req_o    = (state_q == ST_DMA);
    dma_addr_o   = dma_req_o ? addr_q : '0;
    dma_data_o   = dma_req_o ? wdata_q : '0;

    load_valid_o = (state_q == ST_DONE) & ~we_q;
    load_data_o  = load_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i, mem_write_i, d_unsigned_i, dma_en_i;
  logic [3:0]  d_size_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dma_req_o, dma_ack_i;
  logic [31:0] dma_addr_o, dma_data_o, load_data_o;
  logic        load_valid_o, misaligned_o;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .d_size_i(d_size_i), .d_unsigned_i(d_unsigned_i), .dma_en_i(dma_en_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dma_req_o(dma_req_o), .dma_addr_o(dma_addr_o), .dma_data_o(dma_data_o),
    .dma_ack_i(dma_ack_i),
    .load_data_o(load_data_o), .load_valid_o(load_valid_o), .misaligned_o(misaligned_o)
  );

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] load_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic logic [3:0] exp_be(input logic [3:0] size, input logic [1:0] off);
    logic [7:0] w;
    w = {4'b0000, size} << off;
    return w[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] size, input logic [31:0] d);
    if (size == 4'b0001) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (size == 4'b0011) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * off);
    if (size == 4'b0001) return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    if (size == 4'b0011) return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return s;
  endfunction

  // Scoreboard monitor: pops expectations as the DUT completes handshakes.
  always @(negedge clk_i) begin
    bus_t        e;
    logic [31:0] ld;
    if (!rst_i) begin
      if (dmem_req_o && dmem_gnt_i) begin
        if (bus_q.size() == 0) begin
          check_val("dmem_unexpected", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          check_val("dmem_is_mem", {31'b0, e.is_dma}, 32'd0);
          check_val("dmem_we", {31'b0, dmem_we_o}, {31'b0, e.we});
          check_val("dmem_addr", dmem_addr_o, e.addr);
          check_val("dmem_be", {28'b0, dmem_be_o}, {28'b0, e.be});
          if (e.we) check_val("dmem_wdata", dmem_wdata_o, e.data);
        end
      end
      if (dma_req_o && dma_ack_i) begin
        if (bus_q.size() == 0) begin
          check_val("dma_unexpected", 32'd1, 32'd0);
        end else begin
          e = bus_q.pop_front();
          check_val("dma_is_dma", {31'b0, e.is_dma}, 32'd1);
          check_val("dma_addr", dma_addr_o, e.addr);
          check_val("dma_data", dma_data_o, e.data);
        end
      end
      if (load_valid_o) begin
        if (load_q.size() == 0) begin
          check_val("load_unexpected", 32'd1, 32'd0);
        end else begin
          ld = load_q.pop_front();
          check_val("load_data", load_data_o, ld);
        end
      end
    end
  end

  task automatic clear_decoder();
    mem_read_i = 1'b0; mem_write_i = 1'b0; dma_en_i = 1'b0;
    d_unsigned_i = 1'b0; d_size_i = 4'b0000;
  endtask

  // Drives one decoded op and plays the memory / DMA side.
  // wait_n: gnt/ack wait cycles; rv_wait: rvalid cycles after gnt (>=1).
  task automatic run_op(input string name, input logic rd, input logic wr, input logic dma,
                        input logic uns, input logic [3:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int wait_n, input int rv_wait,
                        input logic [31:0] exp_ld, input logic expect_mis);
    bus_t e;
    int   stalls = 0;
    int   req_cycles = 0;
    int   exp_stalls;
    logic bad = 1'b0;
    logic done = 1'b0;
    logic legal;
    logic [31:0] ialign;
    legal  = (rd || wr) && (size == 4'b0001 || size == 4'b0011 || size == 4'b1111);
    ialign = {addr[31:2], 2'b00};

    @(posedge clk_i); #1;
    mem_read_i = rd; mem_write_i = wr; dma_en_i = dma; d_unsigned_i = uns;
    d_size_i = size; addr_i = addr; wdata_i = wdata;
    if (legal && !expect_mis) begin
      if (dma && wr) begin
        e = '{is_dma: 1'b1, we: 1'b1, addr: addr, be: 4'b0, data: wdata};
      end else begin
        e = '{is_dma: 1'b0, we: wr, addr: ialign, be: exp_be(size, addr[1:0]),
              data: exp_wdata(size, wdata)};
      end
      bus_q.push_back(e);
      if (!wr) load_q.push_back(exp_ld);
    end

    @(negedge clk_i);
    if (!legal || expect_mis) begin
      check_val({name, "_misaligned"}, {31'b0, misaligned_o}, {31'b0, expect_mis});
      check_val({name, "_nostall"}, {31'b0, stall_o}, 32'd0);
      check_val({name, "_noreq"}, {31'b0, dmem_req_o | dma_req_o}, 32'd0);
      @(posedge clk_i); #1;
      clear_decoder();
      @(negedge clk_i);
      check_val({name, "_still_idle"}, {30'b0, dmem_req_o, dma_req_o}, 32'd0);
      $display("txn %s: dropped (misaligned=%0b)", name, expect_mis);
      return;
    end
    check_val({name, "_stall_idle"}, {31'b0, stall_o}, 32'd1);
    stalls = 1;
    @(posedge clk_i); #1;
    clear_decoder();

    if (dma && wr) begin
      for (int c = 0; c < 64; c++) begin
        dma_ack_i = (c == wait_n);
        @(negedge clk_i);
        if (stall_o) stalls++;
        if (dma_req_o) req_cycles++;
        if (dmem_req_o || dma_addr_o !== addr || dma_data_o !== wdata) bad = 1'b1;
        @(posedge clk_i); #1;
        if (dma_ack_i) begin
          dma_ack_i = 1'b0;
          done = 1'b1;
          break;
        end
      end
      exp_stalls = wait_n + 2;
    end else begin
      for (int c = 0; c < 64; c++) begin
        dmem_gnt_i    = (c == wait_n);
        dmem_rvalid_i = (c < wait_n);     // stray rvalid while requesting must be ignored
        dmem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        if (stall_o) stalls++;
        if (dmem_req_o) req_cycles++;
        if (dma_req_o || dmem_addr_o !== ialign) bad = 1'b1;
        @(posedge clk_i); #1;
        if (dmem_gnt_i) begin
          dmem_gnt_i = 1'b0;
          dmem_rvalid_i = 1'b0;
          done = 1'b1;
          break;
        end
      end
      if (!wr && done) begin
        done = 1'b0;
        for (int c = 1; c < 64; c++) begin
          dmem_rvalid_i = (c == rv_wait);
          dmem_rdata_i  = (c == rv_wait) ? rdata : 32'hDEAD_BEEF;
          @(negedge clk_i);
          if (stall_o) stalls++;
          if (load_valid_o) bad = 1'b1;
          @(posedge clk_i); #1;
          if (dmem_rvalid_i) begin
            dmem_rvalid_i = 1'b0;
            done = 1'b1;
            break;
          end
        end
      end
      exp_stalls = wait_n + 2 + (wr ? 0 : rv_wait);
    end
    check_val({name, "_timeout"}, {31'b0, done}, 32'd1);
    check_val({name, "_req_cycles"}, req_cycles, wait_n + 1);
    check_val({name, "_port_clean"}, {31'b0, bad}, 32'd0);

    // DONE cycle
    @(negedge clk_i);
    check_val({name, "_done_nostall"}, {31'b0, stall_o}, 32'd0);
    check_val({name, "_done_lvalid"}, {31'b0, load_valid_o}, {31'b0, ~wr});
    check_val({name, "_stalls"}, stalls, exp_stalls);
    $display("txn %s: addr=0x%08h stalls=%0d load_data=0x%08h", name, addr, stalls, load_data_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rd_data;
    logic        rw, ru;
    bus_t        e;

    rst_i = 1'b1;
    clear_decoder();
    addr_i = '0; wdata_i = '0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = '0; dma_ack_i = 0;
    @(negedge clk_i); @(negedge clk_i);
    check_val("reset_ctrl", {24'b0, stall_o, dmem_req_o, dmem_we_o, dma_req_o,
                             load_valid_o, misaligned_o, 2'b00}, 32'd0);
    check_val("reset_data", dmem_addr_o | dmem_wdata_o | dma_addr_o | dma_data_o | {28'b0, dmem_be_o}, 32'd0);
    check_val("reset_load_data", load_data_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    run_op("SB",  0, 1, 0, 0, 4'b0001, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1, 32'h0, 0);
    run_op("LH",  1, 0, 0, 0, 4'b0011, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 3, 32'hFFFF_8001, 0);
    run_op("LHU", 1, 0, 0, 1, 4'b0011, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 3, 32'h0000_8001, 0);
    run_op("LW_mis", 1, 0, 0, 0, 4'b1111, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 32'h0, 1);
    run_op("LH_mis", 1, 0, 0, 0, 4'b0011, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 32'h0, 1);
    run_op("bad_size", 1, 0, 0, 0, 4'b0111, 32'h0000_3000, 32'h0, 32'h0, 0, 1, 32'h0, 0);
    run_op("PIM", 0, 1, 1, 0, 4'b1111, 32'h4000_0010, 32'h0000_0055, 32'h0, 3, 1, 32'h0, 0);
    run_op("SW",  0, 1, 0, 0, 4'b1111, 32'h0000_5000, 32'hCAFE_F00D, 32'h0, 1, 1, 32'h0, 0);
    run_op("LBU", 1, 0, 0, 1, 4'b0001, 32'h0000_5001, 32'h0, 32'h0000_F700, 0, 1, 32'h0000_00F7, 0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    @(posedge clk_i); #1;
    mem_read_i = 1; d_size_i = 4'b1111; addr_i = 32'h0000_6000;
    e = '{is_dma: 1'b0, we: 1'b0, addr: 32'h0000_6000, be: 4'hF, data: 32'h0};
    bus_q.push_back(e);
    @(posedge clk_i); #1;
    clear_decoder();
    dmem_gnt_i = 1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 0;
    @(negedge clk_i);
    check_val("rst_wait_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check_val("rst_mid_ctrl", {24'b0, stall_o, dmem_req_o, dmem_we_o, dma_req_o,
                               load_valid_o, misaligned_o, 2'b00}, 32'd0);
    check_val("rst_mid_data", dmem_addr_o | dmem_wdata_o | dma_addr_o | dma_data_o | load_data_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    check_val("rst_late_rvalid_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    dmem_rvalid_i = 0;
    @(negedge clk_i);
    check_val("rst_late_lvalid", {31'b0, load_valid_o}, 32'd0);
    check_val("rst_late_data", load_data_o, 32'd0);
    $display("txn RST: load aborted in WAIT_R");
    run_op("LB_after_rst", 1, 0, 0, 0, 4'b0001, 32'h0000_7002, 32'h0, 32'h0080_0000, 2, 2, 32'hFFFF_FF80, 0);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0: rs = 4'b0001;
        1: rs = 4'b0011;
        default: rs = 4'b1111;
      endcase
      ra = $urandom;
      if (rs == 4'b0011) ra[0] = 1'b0;
      if (rs == 4'b1111) ra[1:0] = 2'b00;
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      rd_data = $urandom;
      run_op($sformatf("rnd%0d", i), ~rw, rw, 0, ru, rs, ra, $urandom, rd_data,
             $urandom_range(0, 2), $urandom_range(1, 3), exp_load(rs, ru, ra[1:0], rd_data), 0);
    end

    @(negedge clk_i);
    check_val("bus_queue_empty", bus_q.size(), 32'd0);
    check_val("load_queue_empty", load_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the core, directly downstream of the decoder. It consumes the decoded memory controls (size mask, unsigned flag, read/write, DMA enable) with the execute-stage address and store data. It runs one request/grant transaction on the data-memory port, or a request/acknowledge handoff to the DMA/PIM engine. It holds the pipeline until the access completes and returns aligned, sign- or zero-extended load data.

## Interface
- XLEN, 32: data and address width.
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous reset, active-high.
- mem_read_i  in  1  load request from decoder.
- mem_write_i  in  1  store request from decoder.
- d_size_i  in  4  size mask: 0001 byte, 0011 half, 1111 word; any other value means no access.
- d_unsigned_i  in  1  zero-extend load data.
- dma_en_i  in  1  PIM/DMA command; meaningful only with mem_write_i.
- addr_i  in  XLEN  byte address (ALU result).
- wdata_i  in  XLEN  store data (rs2).
- stall_o  out  1  holds all upstream stages.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data.
- dma_req_o  out  1  DMA command valid.
- dma_addr_o  out  XLEN  DMA command address (unaligned, passed through).
- dma_data_o  out  XLEN  DMA command payload.
- dma_ack_i  in  1  DMA command accepted.
- load_data_o  out  XLEN  extended load result to writeback.
- load_valid_o  out  1  load_data_o valid.
- misaligned_o  out  1  misaligned access detected; the access is dropped.

## Operation
- States: IDLE, REQ, WAIT_R, DMA, DONE.
- Op present in IDLE: (mem_read_i | mem_write_i) and d_size_i legal.
- IDLE behaviour:
  - If an op is present and aligned: capture controls, address and data into registers; stall_o=1 combinationally.
  - Next state is DMA if dma_en_i & mem_write_i; otherwise REQ.
- Misalignment:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Response: misaligned_o=1 for that cycle; stall_o=0; no transaction; state stays IDLE.
- dma_en_i takes priority over a normal store. The DMA path never drives dmem_req_o.
- REQ:
  - dmem_req_o=1 with registered we/addr/be/wdata, all stable until gnt.
  - gnt on a store → DONE; gnt on a load → WAIT_R.
- WAIT_R: wait for dmem_rvalid_i, then capture the extended data → DONE.
- DMA: dma_req_o=1 with stable addr/data until dma_ack_i → DONE.
- DONE:
  - stall_o=0, so the pipeline advances at this edge.
  - load_valid_o=1 for loads only.
  - Next state IDLE.
- stall_o=1 in REQ, WAIT_R and DMA.
- Byte enables: dmem_be_o = d_size << addr[1:0], truncated to 4 bits.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load data:
  - Shift: s = rdata >> (8*addr[1:0]).
  - Byte result: s[7:0], sign- or zero-extended per d_unsigned.
  - Half result: s[15:0], sign- or zero-extended per d_unsigned.
  - Word result: s.
- Ignored inputs:
  - dmem_rvalid_i outside WAIT_R.
  - dmem_gnt_i outside REQ.
  - dma_ack_i outside DMA.

## Timing
- Reset values: state IDLE; every output 0, including load_data_o.
- Reset mid-transaction: return to IDLE immediately and drop the access.
  - A response arriving after reset is ignored.
  - The memory side must tolerate a withdrawn request.
- Store, gnt in first REQ cycle: cycle0 IDLE (stall), cycle1 REQ+gnt (stall), cycle2 DONE. Three cycles in stage.
- Load, gnt at cycle1, rvalid at cycle2: cycle3 DONE with load_valid_o. Four cycles minimum.
- rvalid is never in the same cycle as gnt. The earliest rvalid is one cycle after gnt.
- Each gnt wait cycle adds one stall cycle; so does each rvalid wait cycle and each dma_ack wait cycle. No timeout.
- load_data_o holds its value until the next load capture.
- load_valid_o is a 1-cycle pulse.
- Back-to-back ops: the next op is sampled in IDLE on the cycle after DONE; there are no idle bubbles beyond that.

## Test plan
- SB, addr=0x1003, wdata=0xAB, gnt at first REQ cycle → dmem_be=1000, dmem_addr=0x1000, wdata=0xABABABAB; stall high 2 cycles; no rvalid wait.
- LH, addr=0x2002, rdata=0x8001_1234, rvalid 3 cycles after gnt → load_data=0xFFFF8001. Repeat as LHU → 0x00008001. Stall until DONE.
- LW, addr=0x3001 → misaligned_o=1 for one cycle, no dmem_req, stall_o=0. Same check for LH at addr=0x3001.
- PIM store (dma_en, mem_write), addr=0x4000_0010, data=0x55, ack after 4 cycles → dma_req held 4 cycles with stable addr/data, dmem_req stays 0, then DONE.
- Load issued; rst_i asserted in WAIT_R; rvalid arrives after reset release → all outputs 0, load_valid never pulses, next op proceeds normally.
- Back-to-back SW then LBU (addr=0x5001, rdata=0x0000_F700) → two distinct transactions, load_data=0x000000F7, no extra bubble.
